// File: rtl/bcd_display_mux_if.sv
// Bundle between a BCD counter chain and the multiplexed
// seven-segment display driver.
interface bcd_display_mux_if;
  logic [3:0] ones;
  logic [3:0] tens;
  logic [3:0] hundreds;
  logic       carry_in;
  logic       ovf_clr;
  logic       blank_lz;
  logic [2:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       ovf;

  modport master (
    output ones, tens, hundreds,
    output carry_in, ovf_clr, blank_lz,
    input  an, seg, dp, ovf
  );

  modport slave (
    input  ones, tens, hundreds,
    input  carry_in, ovf_clr, blank_lz,
    output an, seg, dp, ovf
  );
endinterface

// File: rtl/bcd_display_mux.sv
// Three-digit common-anode scan driver with per-frame digit
// snapshot, leading-zero blanking and sticky overflow on dp.
module bcd_display_mux #(
  parameter int unsigned REFRESH_DIV = 100_000
) (
  input logic              clk,
  input logic              reset_n,
  bcd_display_mux_if.slave bus
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  localparam logic [1:0] SLOT_ONES = 2'd0;
  localparam logic [1:0] SLOT_TENS = 2'd1;
  localparam logic [1:0] SLOT_HUND = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  logic [PW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [3:0]    o_q, t_q, h_q;
  logic [2:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          ovf_q, ovf_d;
  logic          tick, wrap;
  logic [3:0]    o_s, t_s, h_s, dig;
  logic          blank;

  function automatic logic [6:0] decode(
    input logic [3:0] v
  );
    logic [6:0] r;
    case (v)
      4'd0:    r = 7'h40;
      4'd1:    r = 7'h79;
      4'd2:    r = 7'h24;
      4'd3:    r = 7'h30;
      4'd4:    r = 7'h19;
      4'd5:    r = 7'h12;
      4'd6:    r = 7'h02;
      4'd7:    r = 7'h78;
      4'd8:    r = 7'h00;
      4'd9:    r = 7'h10;
      default: r = SEG_DASH;
    endcase
    return r;
  endfunction

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign wrap  = tick && (slot_q == SLOT_HUND);

  always_comb begin
    slot_d = slot_q;
    if (tick) begin
      unique case (1'b1)
        (slot_q == SLOT_ONES): slot_d = SLOT_TENS;
        (slot_q == SLOT_TENS): slot_d = SLOT_HUND;
        default:               slot_d = SLOT_ONES;
      endcase
    end
  end

  // The wrap edge shows the freshly captured digits, not the old snapshot.
  assign o_s = wrap ? bus.ones     : o_q;
  assign t_s = wrap ? bus.tens     : t_q;
  assign h_s = wrap ? bus.hundreds : h_q;

  always_comb begin
    dig   = o_s;
    blank = 1'b0;
    unique case (1'b1)
      (slot_d == SLOT_TENS): begin
        dig   = t_s;
        blank = bus.blank_lz && h_s == 4'd0
                && t_s == 4'd0;
      end
      (slot_d == SLOT_HUND): begin
        dig   = h_s;
        blank = bus.blank_lz && h_s == 4'd0;
      end
      default: begin
        dig   = o_s;
        blank = 1'b0;
      end
    endcase
  end

  always_comb begin
    an_d = 3'b011;
    unique case (1'b1)
      (slot_d == SLOT_ONES): an_d = 3'b110;
      (slot_d == SLOT_TENS): an_d = 3'b101;
      default:               an_d = 3'b011;
    endcase
  end

  assign seg_d = blank ? SEG_BLANK : decode(dig);
  assign dp_d  = !((slot_d == SLOT_HUND) && ovf_q);
  assign ovf_d = bus.carry_in ? 1'b1
               : bus.ovf_clr ? 1'b0 : ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      slot_q <= SLOT_HUND;
      o_q    <= '0;
      t_q    <= '0;
      h_q    <= '0;
      an_q   <= 3'b111;
      seg_q  <= SEG_BLANK;
      dp_q   <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      ovf_q  <= ovf_d;
      if (wrap) begin
        o_q <= bus.ones;
        t_q <= bus.tens;
        h_q <= bus.hundreds;
      end
      if (tick) begin
        an_q  <= an_d;
        seg_q <= seg_d;
        dp_q  <= dp_d;
      end
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Randomized bench for bcd_display_mux against a cycle-count
// based reference model of the scan schedule.
module tb_bcd_display_mux;

  localparam int R = 4;
  localparam logic [6:0] LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  logic clk;
  logic reset_n;
  bcd_display_mux_if bus ();

  bcd_display_mux #(.REFRESH_DIV(R)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  logic [3:0] cur_d [3];
  logic       cur_c, cur_clr, cur_blz, cur_rn;

  int         e;
  logic [3:0] sn [3];
  logic       ov;
  logic [2:0] ean;
  logic [6:0] eseg;
  logic       edp;
  int         lit;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h",
               tag, $time, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(
    input logic [3:0] v
  );
    if (v > 4'd9) return 7'h3F;
    return LUT[v];
  endfunction

  task automatic model_reset();
    e    = 0;
    ov   = 1'b0;
    ean  = 3'b111;
    eseg = 7'h7F;
    edp  = 1'b1;
    lit  = -1;
    for (int i = 0; i < 3; i++) sn[i] = 4'd0;
  endtask

  task automatic model_edge();
    int s;
    logic bl;
    e++;
    if (e % R == 0) begin
      s = (e / R - 1) % 3;
      if (s == 0)
        for (int i = 0; i < 3; i++) sn[i] = cur_d[i];
      bl = 1'b0;
      if (cur_blz && s == 2) bl = (sn[2] == 0);
      if (cur_blz && s == 1)
        bl = (sn[2] == 0) && (sn[1] == 0);
      ean    = 3'b111;
      ean[s] = 1'b0;
      eseg   = bl ? 7'h7F : seg_of(sn[s]);
      edp    = !(s == 2 && ov);
      lit    = s;
    end
    if (cur_c) ov = 1'b1;
    else if (cur_clr) ov = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    bus.ones     = cur_d[0];
    bus.tens     = cur_d[1];
    bus.hundreds = cur_d[2];
    bus.carry_in = cur_c;
    bus.ovf_clr  = cur_clr;
    bus.blank_lz = cur_blz;
    reset_n      = cur_rn;
    @(posedge clk);
    if (!cur_rn) model_reset();
    else model_edge();
    #1;
    check("disp", {4'd0, bus.an, bus.seg, bus.dp},
                  {4'd0, ean, eseg, edp});
    check("ovf", {15'd0, bus.ovf}, {15'd0, ov});
  endtask

  task automatic set_digits(
    input logic [3:0] o, t, h
  );
    cur_d[0] = o;
    cur_d[1] = t;
    cur_d[2] = h;
  endtask

  function automatic logic [3:0] rnd_digit();
    if ($urandom_range(0, 2) == 0) return 4'd0;
    if ($urandom_range(0, 7) == 0)
      return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    int guard;
    n_vec = 0;
    n_bad = 0;
    reset_n = 1'b0;
    cur_rn  = 1'b0;
    cur_c   = 1'b0;
    cur_clr = 1'b0;
    cur_blz = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3);
    model_reset();
    repeat (2) step();

    cur_rn = 1'b1;
    repeat (30) step();

    cur_blz = 1'b1;
    set_digits(4'd7, 4'd0, 4'd0);
    repeat (3 * R * 2) step();
    cur_blz = 1'b0;
    repeat (3 * R * 2) step();

    cur_blz = 1'b1;
    set_digits(4'd5, 4'd0, 4'hC);
    cur_c = 1'b1;
    step();
    cur_c = 1'b0;
    repeat (3 * R * 2) step();
    cur_c   = 1'b1;
    cur_clr = 1'b1;
    step();
    cur_c = 1'b0;
    repeat (3) step();
    cur_clr = 1'b1;
    step();
    cur_clr = 1'b0;
    repeat (3 * R * 2) step();

    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0)
        set_digits(rnd_digit(), rnd_digit(), rnd_digit());
      cur_c   = ($urandom_range(0, 29) == 0);
      cur_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) cur_blz = ~cur_blz;
      step();
    end
    cur_c   = 1'b0;
    cur_clr = 1'b0;

    cur_c = 1'b1;
    step();
    cur_c = 1'b0;
    set_digits(4'd1, 4'd2, 4'd3);
    cur_blz = 1'b0;
    guard = 0;
    while (!(lit == 1 && e % R == 1) && guard < 50) begin
      step();
      guard++;
    end
    check("seek_tens", {15'd0, guard < 50}, 16'd1);
    #2;
    reset_n = 1'b0;
    cur_rn  = 1'b0;
    #1;
    model_reset();
    check("async_disp", {4'd0, bus.an, bus.seg, bus.dp},
                        {4'd0, 3'b111, 7'h7F, 1'b1});
    check("async_ovf", {15'd0, bus.ovf}, 16'd0);
    repeat (2) step();
    cur_rn = 1'b1;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
